// File: rtl/rf_write_arbiter.sv
// Register-file write-port arbiter. It shares one write port between the core writeback stream
// and memory load returns, and uses a 2-entry bypass FIFO to absorb core writes displaced by a starving return.
module rf_write_arbiter #(
    parameter int ADDR_W   = 5,
    parameter int DATA_W   = 32,
    parameter int MAX_WAIT = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              core_wr_en,
    input  logic [ADDR_W-1:0] core_addr,
    input  logic [DATA_W-1:0] core_data,
    input  logic              mem_valid,
    output logic              mem_ready,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_data,
    output logic              rf_wr_en,
    output logic [ADDR_W-1:0] rf_wr_addr,
    output logic [DATA_W-1:0] rf_wr_data,
    output logic [1:0]        fifo_count,
    output logic              starved
);

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } wr_req_t;

    localparam logic [3:0] MAX_WAIT_C = 4'(MAX_WAIT);

    wr_req_t    fifo_q [2];
    logic       head_q, head_d;
    logic [1:0] count_q, count_d;
    logic [3:0] wait_q, wait_d;
    logic       rf_en_q, rf_en_d;
    wr_req_t    rf_q, rf_d;

    wr_req_t live_req, core_req, grant_req;
    logic    fifo_nonempty, core_avail, at_max;
    logic    grant_mem, grant_core, grant_any;
    logic    pop, push, tail_idx;

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        live_req      = '{addr: core_addr, data: core_data};
        fifo_nonempty = (count_q != 2'd0);
        core_avail    = fifo_nonempty || core_wr_en;
        core_req      = fifo_nonempty ? fifo_q[head_q] : live_req;
        at_max        = (wait_q == MAX_WAIT_C);

        // Gate on rst so that mem_ready stays low while reset is asserted.
        grant_mem  = !rst && mem_valid &&
                     (!core_avail || (at_max && (count_q != 2'd2 || !core_wr_en)));
        grant_core = !rst && !grant_mem && core_avail;
        grant_any  = grant_mem || grant_core;

        pop      = grant_core && fifo_nonempty;
        push     = core_wr_en && (grant_mem || pop);
        // When the FIFO is full and does a push and pop together, the tail equals the slot being popped.
        tail_idx = head_q ^ count_q[0];

        head_d  = pop ? ~head_q : head_q;
        count_d = count_q + {1'b0, push} - {1'b0, pop};

        grant_req = grant_mem ? '{addr: mem_addr, data: mem_data} : core_req;
        rf_d      = grant_any ? grant_req : rf_q;
        // A write to x0 still consumes the slot. It does not assert the write enable.
        rf_en_d   = grant_any && (grant_req.addr != '0);

        wait_d = wait_q;
        if (!mem_valid || grant_mem) begin
            wait_d = 4'd0;
        end else if (!at_max) begin
            wait_d = wait_q + 4'd1;
        end
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head_q  <= 1'b0;
            count_q <= 2'd0;
            wait_q  <= 4'd0;
            rf_en_q <= 1'b0;
            rf_q    <= '0;
        end else begin
            head_q  <= head_d;
            count_q <= count_d;
            wait_q  <= wait_d;
            rf_en_q <= rf_en_d;
            rf_q    <= rf_d;
        end
    end

    // NOTE: the FIFO storage is left unreset. The occupancy count alone decides which entries are valid.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_q[tail_idx] <= live_req;
        end
    end

    assign mem_ready  = grant_mem;
    assign rf_wr_en   = rf_en_q;
    assign rf_wr_addr = rf_q.addr;
    assign rf_wr_data = rf_q.data;
    assign fifo_count = count_q;
    assign starved    = at_max;

endmodule

// File: tb/tb_rf_write_arbiter.sv
// Self-checking bench for rf_write_arbiter. A queue-based model is checked on every negedge,
// and hand-computed literals pin the model at the key scenarios.
module tb_rf_write_arbiter;

    localparam int ADDR_W   = 5;
    localparam int DATA_W   = 32;
    localparam int MAX_WAIT = 4;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              core_wr_en;
    logic [ADDR_W-1:0] core_addr;
    logic [DATA_W-1:0] core_data;
    logic              mem_valid;
    logic              mem_ready;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_data;
    logic              rf_wr_en;
    logic [ADDR_W-1:0] rf_wr_addr;
    logic [DATA_W-1:0] rf_wr_data;
    logic [1:0]        fifo_count;
    logic              starved;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    rf_write_arbiter #(
        .ADDR_W  (ADDR_W),
        .DATA_W  (DATA_W),
        .MAX_WAIT(MAX_WAIT)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .core_wr_en(core_wr_en),
        .core_addr (core_addr),
        .core_data (core_data),
        .mem_valid (mem_valid),
        .mem_ready (mem_ready),
        .mem_addr  (mem_addr),
        .mem_data  (mem_data),
        .rf_wr_en  (rf_wr_en),
        .rf_wr_addr(rf_wr_addr),
        .rf_wr_data(rf_wr_data),
        .fifo_count(fifo_count),
        .starved   (starved)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic cw, input logic [ADDR_W-1:0] ca, input logic [DATA_W-1:0] cd,
                         input logic mv, input logic [ADDR_W-1:0] ma, input logic [DATA_W-1:0] md);
        core_wr_en = cw;
        core_addr  = ca;
        core_data  = cd;
        mem_valid  = mv;
        mem_addr   = ma;
        mem_data   = md;
    endtask

    task automatic idle();
        drive(1'b0, '0, '0, 1'b0, '0, '0);
    endtask

    // Behavioural model: pending core writes held as a queue, plus the memory wait counter.
    typedef struct {
        logic [ADDR_W-1:0] a;
        logic [DATA_W-1:0] d;
    } ent_t;

    ent_t              q[$];
    int                m_wait = 0;
    logic              exp_en = 1'b0;
    logic [ADDR_W-1:0] exp_addr = '0;
    logic [DATA_W-1:0] exp_data = '0;

    always @(negedge clk) begin
        ent_t e;
        logic avail, gm, granted;
        e.a = '0;
        e.d = '0;
        if (rst) begin
            q.delete();
            m_wait   = 0;
            exp_en   = 1'b0;
            exp_addr = '0;
            exp_data = '0;
        end
        check("rf_wr_en", rf_wr_en, exp_en);
        if (exp_en || rst) begin
            check("rf_wr_addr", rf_wr_addr, exp_addr);
            check("rf_wr_data", rf_wr_data, exp_data);
        end
        check("fifo_count", fifo_count, q.size());
        check("starved", starved, m_wait == MAX_WAIT);
        if (rst) begin
            check("mem_ready_in_reset", mem_ready, 0);
        end else begin
            avail = (q.size() > 0) || core_wr_en;
            gm = mem_valid && (!avail || (m_wait == MAX_WAIT && (q.size() < 2 || !core_wr_en)));
            check("mem_ready", mem_ready, gm);
            granted = gm || avail;
            if (gm) begin
                e.a = mem_addr;
                e.d = mem_data;
                if (core_wr_en) q.push_back('{core_addr, core_data});
            end else if (avail) begin
                if (q.size() > 0) begin
                    e = q.pop_front();
                    if (core_wr_en) q.push_back('{core_addr, core_data});
                end else begin
                    e.a = core_addr;
                    e.d = core_data;
                end
            end
            exp_en = granted && (e.a != '0);
            if (granted) begin
                exp_addr = e.a;
                exp_data = e.d;
            end
            if (!mem_valid || gm) m_wait = 0;
            else if (m_wait < MAX_WAIT) m_wait++;
        end
    end

    initial begin
        int   grant_cycle;
        int   idx;
        int   g[3];
        logic mem_done;

        idle();
        repeat (2) step();
        check("reset_rf_wr_en", rf_wr_en, 0);
        check("reset_fifo_count", fifo_count, 0);
        rst = 1'b0;
        step();

        // Core only: three back-to-back writes that bypass the FIFO.
        drive(1'b1, 5'd1, 32'hABCD1234, 1'b0, '0, '0);
        #1 check("core_mem_ready", mem_ready, 0);
        step();
        check("core1_en", rf_wr_en, 1);
        check("core1_addr", rf_wr_addr, 1);
        check("core1_data", rf_wr_data, 32'hABCD1234);
        drive(1'b1, 5'd2, 32'h1, 1'b0, '0, '0);
        step();
        check("core2_addr", rf_wr_addr, 2);
        check("core2_data", rf_wr_data, 1);
        drive(1'b1, 5'd3, 32'h2, 1'b0, '0, '0);
        step();
        check("core3_addr", rf_wr_addr, 3);
        check("core3_data", rf_wr_data, 2);
        check("core3_fifo", fifo_count, 0);

        // Memory only.
        drive(1'b0, '0, '0, 1'b1, 5'd5, 32'h00012345);
        #1 check("memonly_ready", mem_ready, 1);
        step();
        idle();
        check("memonly_en", rf_wr_en, 1);
        check("memonly_addr", rf_wr_addr, 5);
        check("memonly_data", rf_wr_data, 32'h00012345);
        step();

        // Starvation: continuous core writes while a memory return waits.
        grant_cycle = -1;
        mem_done = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (i == 5) begin
                check("starve_rf_addr", rf_wr_addr, 7);
                check("starve_rf_data", rf_wr_data, 32'h77);
                check("starve_fifo", fifo_count, 1);
            end
            drive(1'b1, 5'(10 + i), 32'(32'h100 + i), !mem_done, 5'd7, 32'h77);
            #1;
            if (mem_valid && mem_ready) begin
                grant_cycle = i;
                check("starved_at_grant", starved, 1);
                mem_done = 1'b1;
            end
            step();
        end
        check("starve_grant_cycle", grant_cycle, MAX_WAIT);
        idle();
        step();
        step();
        check("starve_drained", fifo_count, 0);

        // FIFO full: two starvation grants fill the FIFO, and a third return is then blocked.
        idx = 0;
        g[0] = -1;
        g[1] = -1;
        g[2] = -1;
        for (int c = 0; c < 19; c++) begin
            drive(1'b1, 5'(8 + (c % 16)), 32'(32'h2000 + c), idx < 3, 5'(20 + idx), 32'(32'h3000 + idx));
            #1;
            if (c >= 10) check("full_mem_blocked", mem_ready, 0);
            if (mem_valid && mem_ready) begin
                if (idx < 3) g[idx] = c;
                idx++;
            end
            step();
        end
        check("full_grant0", g[0], 4);
        check("full_grant1", g[1], 9);
        check("full_grants", idx, 2);
        drive(1'b0, '0, '0, 1'b1, 5'(20 + idx), 32'(32'h3000 + idx));
        #1;
        check("full_release_ready", mem_ready, 1);
        check("full_count", fifo_count, 2);
        step();
        idle();
        step();
        step();
        check("full_drained", fifo_count, 0);

        // x0: the write consumes the slot but leaves the enable low.
        drive(1'b1, 5'd0, 32'hFFFFFFFF, 1'b0, '0, '0);
        step();
        check("x0_en", rf_wr_en, 0);
        drive(1'b1, 5'd4, 32'h44, 1'b0, '0, '0);
        step();
        check("x4_en", rf_wr_en, 1);
        check("x4_addr", rf_wr_addr, 4);
        idle();
        step();

        // Reset mid-cycle with one FIFO entry pending.
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 5'(1 + i), 32'(32'h500 + i), 1'b1, 5'd9, 32'h99);
            step();
        end
        check("pre_reset_fifo", fifo_count, 1);
        #2 rst = 1'b1;
        #1;
        check("rst_en", rf_wr_en, 0);
        check("rst_addr", rf_wr_addr, 0);
        check("rst_data", rf_wr_data, 0);
        check("rst_fifo", fifo_count, 0);
        check("rst_starved", starved, 0);
        check("rst_mem_ready", mem_ready, 0);
        step();
        rst = 1'b0;
        drive(1'b1, 5'd3, 32'h000AAAAA, 1'b0, '0, '0);
        step();
        check("post_rst_en", rf_wr_en, 1);
        check("post_rst_addr", rf_wr_addr, 3);
        check("post_rst_data", rf_wr_data, 32'h000AAAAA);
        check("post_rst_fifo", fifo_count, 0);
        idle();
        step();
        step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
